// File: rtl/instr_encoder_if.sv
// Request and instruction-stream handshake bundle for instr_encoder.
// The slave modport is the encoder's view. The master modport is the loader/sink view.
interface instr_encoder_if;
   logic        ReqValid;
   logic        ReqReady;
   logic [3:0]  ALUControl;
   logic [4:0]  Rs;
   logic [4:0]  Rt;
   logic [4:0]  Rd;
   logic [4:0]  Shamt;
   logic        InstrValid;
   logic        InstrReady;
   logic [31:0] Instr;
   logic [31:0] InstrAddr;

   modport slave (
      input  ReqValid, ALUControl, Rs, Rt, Rd, Shamt, InstrReady,
      output ReqReady, InstrValid, Instr, InstrAddr
   );

   modport master (
      output ReqValid, ALUControl, Rs, Rt, Rd, Shamt, InstrReady,
      input  ReqReady, InstrValid, Instr, InstrAddr
   );
endinterface

// File: rtl/instr_encoder.sv
// MIPS R-type encoder: ALUControl + register fields -> 32-bit word, FIFO-buffered, sequentially addressed.
// Optional macro ENCODER_ILLEGAL_TRAP_EN: illegal codes are dropped and flag Error instead of becoming NOPs.
module instr_encoder #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     Clear,
   instr_encoder_if.slave           bus,
   output logic [$clog2(DEPTH):0]   Count,
   output logic                     Error
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   r_mem [DEPTH];
   logic [PW-1:0] r_wrPtr;
   logic [PW-1:0] r_rdPtr;
   logic [CW-1:0] r_count;
   logic [31:0]   r_addr;

   logic          w_legal;
   logic [5:0]    w_funct;
   logic [31:0]   w_word;
   logic          w_accept;
   logic          w_push;
   logic          w_pop;

   // ALUControl to Funct map; anything not listed is illegal
   always_comb begin
      w_funct = 6'h00;
      w_legal = 1'b1;
      case (bus.ALUControl)
         4'b0000: w_funct = 6'h24;
         4'b0001: w_funct = 6'h25;
         4'b0010: w_funct = 6'h20;
         4'b0110: w_funct = 6'h22;
         4'b0111: w_funct = 6'h2A;
         4'b1100: w_funct = 6'h27;
         default: w_legal = 1'b0;
      endcase
   end

   assign w_word = w_legal ? {6'b000000, bus.Rs, bus.Rt, bus.Rd, bus.Shamt, w_funct} : 32'h0000_0000;

   assign bus.ReqReady   = (r_count < CW'(DEPTH));
   assign bus.InstrValid = (r_count != '0);
   assign bus.Instr      = bus.InstrValid ? r_mem[r_rdPtr] : 32'h0000_0000;
   assign bus.InstrAddr  = r_addr;
   assign Count          = r_count;

   // Clear outranks both handshakes so a flush never races a push or pop
   assign w_accept = bus.ReqValid && bus.ReqReady && !Clear;
   assign w_pop    = bus.InstrValid && bus.InstrReady && !Clear;

`ifdef ENCODER_ILLEGAL_TRAP_EN
   logic r_error;

   assign w_push = w_accept && w_legal;
   assign Error  = r_error;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_error <= 1'b0;
      else if (Clear)
         r_error <= 1'b0;
      else if (w_accept && !w_legal)
         r_error <= 1'b1;
   end
`else
   assign w_push = w_accept;
   assign Error  = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (w_push)
         r_mem[r_wrPtr] <= w_word;
   end

   // Occupancy alone separates full from empty since the pointers wrap modulo DEPTH
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         r_addr  <= BASE_ADDR;
      end else if (Clear) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         r_addr  <= BASE_ADDR;
      end else begin
         if (w_push)
            r_wrPtr <= r_wrPtr + PW'(1);
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PW'(1);
            r_addr  <= r_addr + 32'd4;
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table vectors plus hand sequences for fill, drain, illegal, reset and clear.
// A second instance near the top of the address space covers address wrap.
module tb_instr_encoder;

   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam logic [31:0] BASEB = 32'hFFFF_FFF8;
`ifdef ENCODER_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   typedef struct {
      logic [3:0]  alu;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  sh;
      logic [31:0] exp;
   } vec_t;

   logic clock;
   logic reset_n;
   logic Clear;
   logic [2:0] countA;
   logic [2:0] countB;
   logic errorA;
   logic errorB;

   instr_encoder_if ifA ();
   instr_encoder_if ifB ();

   instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dutA (
      .clock(clock), .reset_n(reset_n), .Clear(Clear), .bus(ifA), .Count(countA), .Error(errorA)
   );

   instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASEB)) dutB (
      .clock(clock), .reset_n(reset_n), .Clear(Clear), .bus(ifB), .Count(countB), .Error(errorB)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int passCount = 0;
   int checkCount = 0;

   logic [31:0] mq[$];
   int          mCount;
   logic [31:0] mAddr;
   logic        mError;
   vec_t        vecs[6];
   logic [31:0] orWords[6];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp)
         passCount++;
      else
         $display("[TB] FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
   endtask

   task automatic resetModel();
      mq.delete();
      mCount = 0;
      mAddr  = BASE;
      mError = 1'b0;
   endtask

   // Compare instance A against the reference queue at the current negedge
   task automatic checkAll(input string tag);
      checkOutput({tag, ".Count"}, 32'(countA), 32'(mCount));
      checkOutput({tag, ".ReqReady"}, 32'(ifA.ReqReady), 32'(mCount < DEPTH));
      checkOutput({tag, ".InstrValid"}, 32'(ifA.InstrValid), 32'(mCount != 0));
      checkOutput({tag, ".InstrAddr"}, ifA.InstrAddr, mAddr);
      checkOutput({tag, ".Error"}, 32'(errorA), 32'(mError));
      if (mCount != 0)
         checkOutput({tag, ".Instr"}, ifA.Instr, mq[0]);
   endtask

   // One cycle: check, drive, advance reference, wait for the next negedge
   task automatic applyStimulus(input string tag, input logic rv, input logic [3:0] alu,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic [4:0] sh, input logic [31:0] expWord, input logic legal,
                                input logic ir, input logic clr);
      logic accept;
      logic pop;
      checkAll(tag);
      ifA.ReqValid   = rv;
      ifA.ALUControl = alu;
      ifA.Rs         = rs;
      ifA.Rt         = rt;
      ifA.Rd         = rd;
      ifA.Shamt      = sh;
      ifA.InstrReady = ir;
      Clear          = clr;
      accept = rv && (mCount < DEPTH) && !clr;
      pop    = ir && (mCount != 0) && !clr;
      if (clr) begin
         resetModel();
      end else begin
         if (pop) begin
            void'(mq.pop_front());
            mAddr = mAddr + 32'd4;
         end
         if (accept) begin
            if (legal || !TRAP)
               mq.push_back(expWord);
            else
               mError = 1'b1;
         end
         mCount = mq.size();
      end
      @(negedge clock);
   endtask

   initial begin
      vecs[0] = '{OP_ADD, 5'd1,  5'd2,  5'd3,  5'd0,  32'h0022_1820};
      vecs[1] = '{OP_AND, 5'd4,  5'd5,  5'd6,  5'd0,  32'h0085_3024};
      vecs[2] = '{OP_OR,  5'd31, 5'd31, 5'd31, 5'd31, 32'h03FF_FFE5};
      vecs[3] = '{OP_SUB, 5'd0,  5'd0,  5'd0,  5'd5,  32'h0000_0162};
      vecs[4] = '{OP_SLT, 5'd7,  5'd8,  5'd9,  5'd0,  32'h00E8_482A};
      vecs[5] = '{OP_NOR, 5'd16, 5'd1,  5'd2,  5'd0,  32'h0201_1027};
      orWords = '{32'h0000_0825, 32'h0000_1025, 32'h0000_1825,
                  32'h0000_2025, 32'h0000_2825, 32'h0000_3025};

      reset_n = 1'b0;
      Clear   = 1'b0;
      ifA.ReqValid = 1'b0; ifA.ALUControl = 4'h0; ifA.Rs = '0; ifA.Rt = '0; ifA.Rd = '0;
      ifA.Shamt = '0; ifA.InstrReady = 1'b0;
      ifB.ReqValid = 1'b0; ifB.ALUControl = 4'h0; ifB.Rs = '0; ifB.Rt = '0; ifB.Rd = '0;
      ifB.Shamt = '0; ifB.InstrReady = 1'b0;
      resetModel();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      checkOutput("rst.Instr", ifA.Instr, 32'h0);
      checkOutput("rst.InstrValid", 32'(ifA.InstrValid), 32'd0);
      checkOutput("rst.ReqReady", 32'(ifA.ReqReady), 32'd1);

      // First word: visible one cycle after accept, gone the cycle after
      applyStimulus("first", 1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0022_1820, 1'b1, 1'b1, 1'b0);
      applyStimulus("first", 1'b0, OP_ADD, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0);

      for (int i = 0; i < 6; i++)
         applyStimulus("table", 1'b1, vecs[i].alu, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh,
                       vecs[i].exp, 1'b1, 1'b1, 1'b0);
      applyStimulus("table", 1'b0, OP_AND, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0);
      applyStimulus("table", 1'b0, OP_AND, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Fill to full, hold a fifth request, then stream with both sides busy
      applyStimulus("fill", 1'b1, OP_SUB, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0022, 1'b1, 1'b0, 1'b0);
      applyStimulus("fill", 1'b1, OP_SLT, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0000_002A, 1'b1, 1'b0, 1'b0);
      applyStimulus("fill", 1'b1, OP_NOR, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0027, 1'b1, 1'b0, 1'b0);
      applyStimulus("fill", 1'b1, OP_AND, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0024, 1'b1, 1'b0, 1'b0);
      applyStimulus("held", 1'b1, OP_ADD, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0020, 1'b1, 1'b0, 1'b0);
      applyStimulus("stream", 1'b1, OP_ADD, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0020, 1'b1, 1'b1, 1'b0);
      applyStimulus("stream", 1'b1, OP_ADD, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0020, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++)
         applyStimulus("stream", 1'b1, OP_OR, 5'd0, 5'd0, 5'(i + 1), 5'd0, orWords[i], 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++)
         applyStimulus("drain", 1'b0, OP_AND, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0);

      // Illegal code followed by a legal word, then Clear drops the sticky flag
      applyStimulus("illegal", 1'b1, 4'b1111, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
      applyStimulus("illegal", 1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0022_1820, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         applyStimulus("illegal", 1'b0, OP_AND, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0);
      applyStimulus("clrerr", 1'b0, OP_AND, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1);

      // Asynchronous reset with three words buffered
      for (int i = 0; i < 3; i++)
         applyStimulus("prerst", 1'b1, vecs[i].alu, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh,
                       vecs[i].exp, 1'b1, 1'b0, 1'b0);
      applyStimulus("prerst", 1'b0, OP_AND, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
      checkAll("prerst");
      #2 reset_n = 1'b0;
      #1;
      checkOutput("arst.InstrValid", 32'(ifA.InstrValid), 32'd0);
      checkOutput("arst.Count", 32'(countA), 32'd0);
      checkOutput("arst.InstrAddr", ifA.InstrAddr, BASE);
      resetModel();
      #1 reset_n = 1'b1;
      @(negedge clock);

      // Clear with a request pending: nothing accepted, nothing popped
      for (int i = 3; i < 6; i++)
         applyStimulus("preclr", 1'b1, vecs[i].alu, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh,
                       vecs[i].exp, 1'b1, 1'b1, 1'b0);
      applyStimulus("preclr", 1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0022_1820, 1'b1, 1'b0, 1'b0);
      applyStimulus("preclr", 1'b1, OP_AND, 5'd4, 5'd5, 5'd6, 5'd0, 32'h0085_3024, 1'b1, 1'b0, 1'b0);
      applyStimulus("clear", 1'b1, OP_OR, 5'd31, 5'd31, 5'd31, 5'd31, 32'h03FF_FFE5, 1'b1, 1'b1, 1'b1);
      applyStimulus("postclr", 1'b0, OP_AND, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0);
      checkAll("postclr");

      // Address wrap past 2^32 on the high-base instance
      ifB.ReqValid = 1'b1; ifB.ALUControl = OP_ADD; ifB.Rs = 5'd1; ifB.Rt = 5'd2; ifB.Rd = 5'd3;
      ifB.InstrReady = 1'b0;
      repeat (3) @(negedge clock);
      ifB.ReqValid = 1'b0;
      checkOutput("wrap.Count", 32'(countB), 32'd3);
      checkOutput("wrap.Instr", ifB.Instr, 32'h0022_1820);
      checkOutput("wrap.Addr0", ifB.InstrAddr, 32'hFFFF_FFF8);
      checkOutput("wrap.Error", 32'(errorB), 32'd0);
      ifB.InstrReady = 1'b1;
      @(negedge clock);
      checkOutput("wrap.Addr1", ifB.InstrAddr, 32'hFFFF_FFFC);
      @(negedge clock);
      checkOutput("wrap.Addr2", ifB.InstrAddr, 32'h0000_0000);
      checkOutput("wrap.Valid2", 32'(ifB.InstrValid), 32'd1);
      @(negedge clock);
      checkOutput("wrap.CountEnd", 32'(countB), 32'd0);
      checkOutput("wrap.Addr3", ifB.InstrAddr, 32'h0000_0004);
      ifB.InstrReady = 1'b0;

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
